uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_if.sv | 25 ++
 rtl/uart_tx_arb.sv | 125 ++++++++++++
 tb/tb_uart_tx_arb.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester / transmitter bus of the UART TX arbiter.
// slave: the arbiter; master: requesters plus transmitter (e.g. a testbench).
interface uart_tx_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_din;
  logic               tx_wr_en;
  logic               tx_busy;
  logic [N_REQ-1:0]   grant;
  logic               pkt_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_din, tx_wr_en, grant, pkt_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_din, tx_wr_en, grant, pkt_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding N_REQ byte streams into one UART transmitter,
// one byte in flight, packets locked to their owner up to MAX_PKT bytes.
module uart_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int MAX_PKT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_arb_if.slave   bus
);
  localparam int              PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW:0]     NR   = (PW+1)'(N_REQ);
  localparam logic [7:0]      MAXC = 8'(MAX_PKT);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [PW-1:0]    r_ptr, r_owner, w_winner;
  logic [PW:0]      w_sum;
  logic             w_any;
  logic [7:0]       r_cnt;
  logic             r_last;
  logic [2:0]       r_wait;
  logic [7:0]       r_tx_din;
  logic             r_tx_wr_en;
  logic [N_REQ-1:0] r_grant;
  logic             r_pkt_err;
  logic             w_accept, w_to_idle, w_err;

  // Walk offsets high to low so the smallest offset from ptr is written last.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= NR) w_sum = w_sum - NR;
      if (bus.req_valid[w_sum[PW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_to_idle = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      S_IDLE:      if (w_any && !bus.tx_busy) w_next = S_HOLD;
      S_HOLD:      if (bus.req_valid[r_owner]) begin
                     w_accept = 1'b1;
                     w_next   = S_ISSUE;
                   end
      S_ISSUE:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.tx_busy) w_next = S_WAIT_DONE;
                   else if (r_wait == 3'd4) begin
                     // transmitter never acknowledged the write
                     w_next    = S_IDLE;
                     w_to_idle = 1'b1;
                     w_err     = 1'b1;
                   end
      S_WAIT_DONE: if (!bus.tx_busy) begin
                     if (r_last || r_cnt == MAXC) begin
                       w_next    = S_IDLE;
                       w_to_idle = 1'b1;
                       w_err     = !r_last;
                     end else begin
                       w_next = S_HOLD;
                     end
                   end
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_wait     <= '0;
      r_tx_din   <= 8'h00;
      r_tx_wr_en <= 1'b0;
      r_grant    <= '0;
      r_pkt_err  <= 1'b0;
    end else begin
      r_tx_wr_en <= w_accept;
      if (r_state == S_IDLE && w_next == S_HOLD) begin
        r_owner <= w_winner;
        r_grant <= ONE << w_winner;
      end
      if (w_accept) begin
        r_tx_din <= bus.req_data[{r_owner, 3'b000} +: 8];
        r_last   <= bus.req_last[r_owner];
        if (r_cnt != MAXC) r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == S_ISSUE)
        r_wait <= 3'd1;
      else if (r_state == S_WAIT_BUSY && !bus.tx_busy && r_wait != 3'd4)
        r_wait <= r_wait + 3'd1;
      if (w_to_idle) begin
        r_grant <= '0;
        r_cnt   <= '0;
        r_ptr   <= (r_owner == PW'(N_REQ-1)) ? '0 : r_owner + PW'(1);
      end
      if (w_err) r_pkt_err <= 1'b1;
    end
  end

  assign bus.req_ready = (r_state == S_HOLD) ? (r_grant & bus.req_valid) : '0;
  assign bus.tx_din    = r_tx_din;
  assign bus.tx_wr_en  = r_tx_wr_en;
  assign bus.grant     = r_grant;
  assign bus.pkt_err   = r_pkt_err;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: randomized and directed packets, per-requester
// expected queues, round-robin model on grant edges, transmitter behaviour model.
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int MP = 4;

  typedef struct {
    logic [7:0] d;
    bit         last;
  } byte_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N)) bus ();
  uart_tx_arb #(.N_REQ(N), .MAX_PKT(MP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  byte_t      drv_q[N][$];
  byte_t      exp_q[N][$];
  int         log_lane[$];
  logic [7:0] log_data[$];
  byte_t      cur[N];
  bit         cur_v[N];
  bit         eager = 1'b1, stall = 1'b0, long_busy = 1'b0;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference round-robin: first requester at or after p, wrapping.
  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic push_byte(input int ln, input logic [7:0] d, input bit last);
    byte_t it;
    it.d = d; it.last = last;
    drv_q[ln].push_back(it);
    exp_q[ln].push_back(it);
  endtask

  task automatic push_pkt(input int ln, input int len);
    for (int b = 0; b < len; b++) push_byte(ln, 8'($urandom), b == len-1);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush();
    repeat (3) @(posedge clk);
    flush();
    #2 rst_n = 1'b1;
  endtask

  function automatic bit idle_all();
    bit e;
    e = (bus.grant == '0) && !bus.tx_busy;
    for (int i = 0; i < N; i++)
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0 || cur_v[i]) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input int budget);
    int c;
    bit done;
    done = 1'b0;
    for (c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = idle_all();
    end
    chk(done, "drain_timeout", c, budget);
  endtask

  // Requester driver: each lane presents its queued bytes, holding until accepted.
  initial begin
    logic [N-1:0] acc;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    for (int i = 0; i < N; i++) begin cur_v[i] = 1'b0; cur[i].d = 8'h00; cur[i].last = 1'b0; end
    forever begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst_n) cur_v[i] = 1'b0;
        else begin
          if (cur_v[i] && acc[i]) cur_v[i] = 1'b0;
          if (!cur_v[i] && drv_q[i].size() > 0 && (eager || $urandom_range(0, 3) != 0)) begin
            cur[i]   = drv_q[i].pop_front();
            cur_v[i] = 1'b1;
          end
        end
        bus.req_valid[i]      = cur_v[i];
        bus.req_data[8*i +: 8] = cur[i].d;
        bus.req_last[i]       = cur[i].last;
      end
    end
  end

  // Transmitter model: busy rises the cycle after a write, stays up a few cycles.
  initial begin
    logic wr;
    int   bcnt;
    bcnt = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      wr = bus.tx_wr_en;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.tx_busy = 1'b0; bcnt = 0;
      end else if (wr && !stall) begin
        bus.tx_busy = 1'b1;
        bcnt = long_busy ? 8 : $urandom_range(1, 5);
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int           mptr, cnt, ow, w;
    bit           lastseen;
    logic [N-1:0] pv, pg, pr, g;
    byte_t        e;
    mptr = 0; cnt = 0; lastseen = 1'b0; pv = '0; pg = '0; pr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mptr = 0; cnt = 0; lastseen = 1'b0; pv = '0; pg = '0; pr = '0;
      end else begin
        g = bus.grant;
        if ((|pr) || bus.tx_wr_en) chk((|pr) == bus.tx_wr_en, "accept_to_wr", bus.tx_wr_en, |pr);
        if (bus.tx_wr_en) begin
          chk(!bus.tx_busy, "wr_while_busy", bus.tx_busy, 0);
          chk($onehot(g), "grant_onehot_on_wr", g, 0);
          ow = oh_idx(g);
          if (ow >= 0) begin
            chk(exp_q[ow].size() > 0, "byte_expected", exp_q[ow].size(), 1);
            if (exp_q[ow].size() > 0) begin
              e = exp_q[ow].pop_front();
              chk(bus.tx_din == e.d, "tx_din", bus.tx_din, e.d);
              lastseen = e.last;
            end
            log_lane.push_back(ow);
            log_data.push_back(bus.tx_din);
          end
          cnt++;
          chk(cnt <= MP, "pkt_len", cnt, MP);
        end
        if (|bus.req_ready)
          chk($onehot(bus.req_ready) && ((bus.req_ready & ~g) == '0), "ready_vs_grant", bus.req_ready, g);
        if (pg == '0 && g != '0) begin
          w = rr_pick(mptr, pv);
          chk(w >= 0 && g == (N'(1) << w), "rr_grant", g, (w >= 0) ? (1 << w) : 0);
          cnt = 0; lastseen = 1'b0;
        end
        if (pg != '0 && g != '0) chk(g == pg, "no_preempt", g, pg);
        if (pg != '0 && g == '0) begin
          chk(lastseen || cnt == MP || stall, "pkt_release", cnt, MP);
          mptr = (oh_idx(pg) + 1) % N;
        end
        pv = bus.req_valid; pg = g; pr = bus.req_ready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int nwr;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus.grant == '0,     "rst_grant",   bus.grant, 0);
    chk(bus.req_ready == '0, "rst_ready",   bus.req_ready, 0);
    chk(!bus.tx_wr_en,       "rst_wr_en",   bus.tx_wr_en, 0);
    chk(bus.tx_din == 8'h00, "rst_tx_din",  bus.tx_din, 0);
    chk(!bus.pkt_err,        "rst_pkt_err", bus.pkt_err, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // single byte from requester 0
    log_lane.delete(); log_data.delete();
    push_byte(0, 8'hA5, 1'b1);
    wait_drain(200);
    chk(log_lane.size() == 1, "single_count", log_lane.size(), 1);
    if (log_lane.size() == 1) begin
      chk(log_lane[0] == 0,     "single_lane", log_lane[0], 0);
      chk(log_data[0] == 8'hA5, "single_data", log_data[0], 8'hA5);
    end

    // continuous one-byte packets on all lanes; ptr is 1 after the previous packet
    log_lane.delete(); log_data.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_byte(i, 8'(16*i + r + 1), 1'b1);
    wait_drain(1000);
    chk(log_lane.size() == 2*N, "rr_count", log_lane.size(), 2*N);
    for (int k = 0; k < log_lane.size() && k < 2*N; k++)
      chk(log_lane[k] == (k + 1) % N, "rr_order", log_lane[k], (k + 1) % N);

    // packet lock: requester 2 holds the transmitter for its whole packet
    log_lane.delete(); log_data.delete();
    push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h33, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.grant == 4'b0100);
    end
    chk(seen, "lock_grant2", bus.grant, 4'b0100);
    push_byte(0, 8'h5A, 1'b1);
    wait_drain(1000);
    chk(log_lane.size() == 4, "lock_count", log_lane.size(), 4);
    if (log_lane.size() == 4) begin
      chk(log_lane[2] == 2 && log_data[2] == 8'h33, "lock_third", log_data[2], 8'h33);
      chk(log_lane[3] == 0 && log_data[3] == 8'h5A, "lock_then_0", log_lane[3], 0);
    end
    chk(!bus.pkt_err, "no_err_after_lock", bus.pkt_err, 0);

    // randomized traffic, packets up to MAX_PKT bytes with last
    eager = 1'b0;
    for (int p = 0; p < 30; p++) begin
      push_pkt($urandom_range(0, N-1), $urandom_range(1, MP));
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    wait_drain(8000);
    chk(!bus.pkt_err, "no_err_random", bus.pkt_err, 0);
    eager = 1'b1;

    // MAX_PKT forced release
    do_reset();
    log_lane.delete(); log_data.delete();
    for (int b = 0; b < 6; b++) push_byte(1, 8'(8'hB0 + b), b == 5);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = bus.pkt_err;
    end
    chk(seen, "maxpkt_err", bus.pkt_err, 1);
    chk(log_lane.size() == MP, "maxpkt_release_len", log_lane.size(), MP);
    wait_drain(1000);
    chk(log_lane.size() == 6, "maxpkt_total", log_lane.size(), 6);
    chk(bus.pkt_err, "maxpkt_err_sticky", bus.pkt_err, 1);

    // stalled transmitter
    do_reset();
    stall = 1'b1;
    push_byte(3, 8'hC3, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = bus.tx_wr_en;
    end
    chk(seen, "stall_first_wr", bus.tx_wr_en, 1);
    repeat (4) @(negedge clk);
    chk(bus.grant == 4'b1000 && !bus.pkt_err, "stall_still_waiting", bus.grant, 4'b1000);
    @(negedge clk);
    chk(bus.grant == '0, "stall_grant_clear", bus.grant, 0);
    chk(bus.pkt_err,     "stall_pkt_err", bus.pkt_err, 1);
    nwr = 0;
    repeat (10) begin @(negedge clk); if (bus.tx_wr_en) nwr++; end
    chk(nwr == 0, "stall_no_second_wr", nwr, 0);
    stall = 1'b0;

    // reset in WAIT_DONE, then priority restarts at requester 0
    do_reset();
    push_byte(2, 8'h44, 1'b1);
    wait_drain(300);
    long_busy = 1'b1;
    push_byte(2, 8'h77, 1'b0); push_byte(2, 8'h78, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = bus.tx_busy && (bus.grant != '0);
    end
    chk(seen, "mid_reach_busy", bus.tx_busy, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(bus.grant == '0 && bus.req_ready == '0, "mid_rst_grant", bus.grant, 0);
    chk(!bus.tx_wr_en && bus.tx_din == 8'h00,   "mid_rst_tx", bus.tx_din, 0);
    chk(!bus.pkt_err, "mid_rst_err", bus.pkt_err, 0);
    flush();
    nwr = 0;
    repeat (3) begin @(negedge clk); if (bus.tx_wr_en) nwr++; end
    chk(nwr == 0, "mid_rst_no_wr", nwr, 0);
    long_busy = 1'b0;
    flush();
    @(posedge clk);
    #2 rst_n = 1'b1;
    log_lane.delete(); log_data.delete();
    push_byte(3, 8'h93, 1'b1); push_byte(1, 8'h91, 1'b1);
    wait_drain(500);
    chk(log_lane.size() == 2, "post_rst_count", log_lane.size(), 2);
    if (log_lane.size() == 2) begin
      chk(log_lane[0] == 1, "post_rst_first", log_lane[0], 1);
      chk(log_lane[1] == 3, "post_rst_second", log_lane[1], 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
